// File: rtl/change_dispenser.sv
// change_dispenser: pays out an owed amount with a greedy coin breakdown over
// three denominations, tracks per-coin inventory, and talks to the coin
// ejector through a req/ack handshake. A payout ends with a one-cycle done
// pulse, or a one-cycle error pulse if it cannot be completed.
module change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int INV_W       = 6,
    parameter int DEN_HI      = 20,
    parameter int DEN_MID     = 10,
    parameter int DEN_LO      = 5,
    parameter int INV_INIT    = 20,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             coin_eject_ack,
    input  logic             refill,
    output logic             coin_eject,
    output logic [1:0]       coin_sel,
    output logic             change_dispense_done,
    output logic             change_error,
    output logic             busy,
    output logic [AMT_W-1:0] remaining,
    output logic [2:0]       inv_empty
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [AMT_W-1:0] C_DEN_HI   = AMT_W'(DEN_HI);
    localparam logic [AMT_W-1:0] C_DEN_MID  = AMT_W'(DEN_MID);
    localparam logic [AMT_W-1:0] C_DEN_LO   = AMT_W'(DEN_LO);
    localparam logic [INV_W-1:0] C_INV_INIT = INV_W'(INV_INIT);
    localparam logic [TMR_W-1:0] C_TIMEOUT  = TMR_W'(ACK_TIMEOUT);

    // coin_sel encodings
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_LO   = 2'd1;
    localparam logic [1:0] SEL_MID  = 2'd2;
    localparam logic [1:0] SEL_HI   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [AMT_W-1:0]   r_remaining;
    logic [INV_W-1:0]   r_invHi;
    logic [INV_W-1:0]   r_invMid;
    logic [INV_W-1:0]   r_invLo;
    logic [1:0]         r_coinSel;
    logic [TMR_W-1:0]   r_ackTimer;
    logic [1:0]         w_pick;
    logic [AMT_W-1:0]   w_coinDen;

    // Greedy choice: largest coin that still fits the residue and is in stock.
    always_comb begin
        w_pick = SEL_NONE;
        if (r_remaining >= C_DEN_HI && r_invHi != '0) begin
            w_pick = SEL_HI;
        end else if (r_remaining >= C_DEN_MID && r_invMid != '0) begin
            w_pick = SEL_MID;
        end else if (r_remaining >= C_DEN_LO && r_invLo != '0) begin
            w_pick = SEL_LO;
        end
    end

    // Value of the coin currently being ejected.
    always_comb begin
        w_coinDen = '0;
        case (r_coinSel)
            SEL_HI:  w_coinDen = C_DEN_HI;
            SEL_MID: w_coinDen = C_DEN_MID;
            SEL_LO:  w_coinDen = C_DEN_LO;
            default: w_coinDen = '0;
        endcase
    end

    // State register; reset aborts any payout immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. An ack on the same edge the timer expires wins.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = (change_amount == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining == '0) begin
                    w_nextState = S_DONE;
                end else if (w_pick != SEL_NONE) begin
                    w_nextState = S_EJECT;
                end else begin
                    w_nextState = S_ERROR;
                end
            end
            S_EJECT: begin
                if (coin_eject_ack) begin
                    w_nextState = S_SELECT;
                end else if (r_ackTimer >= C_TIMEOUT) begin
                    w_nextState = S_ERROR;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            S_ERROR: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Amount owed: loaded on an accepted start, reduced per acknowledged coin,
    // cleared on done, and left holding the residue after an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_remaining <= change_amount;
        end else if (r_state == S_EJECT && coin_eject_ack) begin
            r_remaining <= r_remaining - w_coinDen;
        end else if (r_state == S_DONE) begin
            r_remaining <= '0;
        end
    end

    // Coin type latched in SELECT and held stable through EJECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coinSel <= SEL_NONE;
        end else if (r_state == S_SELECT) begin
            r_coinSel <= w_pick;
        end else if (r_state == S_DONE || r_state == S_ERROR) begin
            r_coinSel <= SEL_NONE;
        end
    end

    // Ack timer: reads 1 in the first EJECT cycle and saturates at the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ackTimer <= '0;
        end else if (r_state == S_SELECT) begin
            r_ackTimer <= TMR_W'(1);
        end else if (r_state == S_EJECT && !coin_eject_ack && r_ackTimer < C_TIMEOUT) begin
            r_ackTimer <= r_ackTimer + TMR_W'(1);
        end else if (r_state != S_EJECT) begin
            r_ackTimer <= '0;
        end
    end

    // Inventories: refilled only from IDLE without a start, and decremented
    // once per acknowledged coin (never below zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_invHi  <= C_INV_INIT;
            r_invMid <= C_INV_INIT;
            r_invLo  <= C_INV_INIT;
        end else if (r_state == S_IDLE && refill && !start) begin
            r_invHi  <= C_INV_INIT;
            r_invMid <= C_INV_INIT;
            r_invLo  <= C_INV_INIT;
        end else if (r_state == S_EJECT && coin_eject_ack) begin
            if (r_coinSel == SEL_HI && r_invHi != '0) begin
                r_invHi <= r_invHi - INV_W'(1);
            end
            if (r_coinSel == SEL_MID && r_invMid != '0) begin
                r_invMid <= r_invMid - INV_W'(1);
            end
            if (r_coinSel == SEL_LO && r_invLo != '0) begin
                r_invLo <= r_invLo - INV_W'(1);
            end
        end
    end

    // Outputs are decoded from state so they fall together with rst_n.
    always_comb begin
        coin_eject           = (r_state == S_EJECT);
        coin_sel             = (r_state == S_EJECT) ? r_coinSel : SEL_NONE;
        change_dispense_done = (r_state == S_DONE);
        change_error         = (r_state == S_ERROR);
        busy                 = (r_state != S_IDLE);
        remaining            = r_remaining;
        inv_empty            = {r_invHi == '0, r_invMid == '0, r_invLo == '0};
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed bench with an expected-coin scoreboard.
// Instance A uses the default inventory, instance B starts with one coin of
// each kind so that depletion can be reached quickly.
module tb_change_dispenser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       ack;
   logic       refill;
   logic       useB;
   logic [7:0] amount;

   logic       startA, startB, ackA, ackB, refillA, refillB;
   logic       ejA, ejB, doneA, doneB, errA, errB, busyA, busyB;
   logic [1:0] selA, selB;
   logic [7:0] remA, remB;
   logic [2:0] emA, emB;

   logic       coinEject, done, err, busy;
   logic [1:0] coinSel;
   logic [7:0] rem;
   logic [2:0] invEmpty;

   int nChecks = 0;
   int nPass   = 0;

   logic [1:0] expCoins[$];

   int rEject, rEjectCycles, rDone, rError, rBusy, rDoneCycle;

   change_dispenser dutA (
      .clk(clk), .rst_n(rst_n), .start(startA), .change_amount(amount),
      .coin_eject_ack(ackA), .refill(refillA), .coin_eject(ejA), .coin_sel(selA),
      .change_dispense_done(doneA), .change_error(errA), .busy(busyA),
      .remaining(remA), .inv_empty(emA)
   );

   change_dispenser #(.INV_INIT(1)) dutB (
      .clk(clk), .rst_n(rst_n), .start(startB), .change_amount(amount),
      .coin_eject_ack(ackB), .refill(refillB), .coin_eject(ejB), .coin_sel(selB),
      .change_dispense_done(doneB), .change_error(errB), .busy(busyB),
      .remaining(remB), .inv_empty(emB)
   );

   // Route the shared stimulus to the selected instance and observe it.
   always_comb begin
      startA    = start & ~useB;
      startB    = start & useB;
      ackA      = ack & ~useB;
      ackB      = ack & useB;
      refillA   = refill & ~useB;
      refillB   = refill & useB;
      coinEject = useB ? ejB : ejA;
      coinSel   = useB ? selB : selA;
      done      = useB ? doneB : doneA;
      err       = useB ? errB : errA;
      busy      = useB ? busyB : busyA;
      rem       = useB ? remB : remA;
      invEmpty  = useB ? emB : emA;
   end

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) nPass++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   // Pulse start (optionally with refill) for one cycle, inputs changed on negedge.
   task automatic applyStimulus(input logic [7:0] amt, input logic withRefill);
      @(negedge clk);
      amount = amt;
      start  = 1'b1;
      refill = withRefill;
      @(negedge clk);
      start  = 1'b0;
      refill = 1'b0;
   endtask

   // Start a payout and act as the ejector: ack after ackDelay extra EJECT
   // cycles (negative = never). Each new eject pops an expected coin.
   task automatic runPayout(input logic [7:0] amt, input int ackDelay, input logic withRefill);
      int  highRun;
      bit  finished;
      logic [1:0] expSel;
      rEject = 0; rEjectCycles = 0; rDone = 0; rError = 0; rBusy = 0; rDoneCycle = -1;
      highRun  = 0;
      finished = 1'b0;
      applyStimulus(amt, withRefill);
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (busy) rBusy++;
         if (done) begin
            rDone++;
            rDoneCycle = cyc;
            finished   = 1'b1;
         end
         if (err) begin
            rError++;
            finished = 1'b1;
         end
         if (coinEject) begin
            rEjectCycles++;
            if (highRun == 0) begin
               rEject++;
               if (expCoins.size() > 0) begin
                  expSel = expCoins.pop_front();
                  checkOutput("coinSel", 32'(coinSel), 32'(expSel));
               end else begin
                  checkOutput("unexpectedCoin", 32'(expCoins.size()), 32'd1);
               end
            end
            highRun++;
            ack = (ackDelay >= 0 && highRun > ackDelay);
         end else begin
            highRun = 0;
            ack     = 1'b0;
         end
         if (!finished) @(negedge clk);
      end
      ack = 1'b0;
      checkOutput("payoutEnds", 32'(finished), 32'd1);
      checkOutput("coinsLeft", 32'(expCoins.size()), 32'd0);
      @(negedge clk);
      checkOutput("idleAfter", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b1;
      start  = 1'b0;
      ack    = 1'b0;
      refill = 1'b0;
      useB   = 1'b0;
      amount = 8'd0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state.
      checkOutput("rstEject", 32'(ejA), 32'd0);
      checkOutput("rstSel", 32'(selA), 32'd0);
      checkOutput("rstDone", 32'(doneA), 32'd0);
      checkOutput("rstErr", 32'(errA), 32'd0);
      checkOutput("rstBusy", 32'(busyA), 32'd0);
      checkOutput("rstRem", 32'(remA), 32'd0);
      checkOutput("rstEmptyA", 32'(emA), 32'd0);
      checkOutput("rstEmptyB", 32'(emB), 32'd0);
      rst_n = 1'b1;

      // 35 with full stock: 20 + 10 + 5.
      expCoins.push_back(2'd3); expCoins.push_back(2'd2); expCoins.push_back(2'd1);
      runPayout(8'd35, 0, 1'b0);
      checkOutput("t35Ejects", 32'(rEject), 32'd3);
      checkOutput("t35Done", 32'(rDone), 32'd1);
      checkOutput("t35Err", 32'(rError), 32'd0);
      checkOutput("t35Rem", 32'(rem), 32'd0);
      checkOutput("t35Empty", 32'(invEmpty), 32'd0);

      // Zero amount: done straight away, busy for one cycle.
      runPayout(8'd0, 0, 1'b0);
      checkOutput("t0Ejects", 32'(rEject), 32'd0);
      checkOutput("t0Done", 32'(rDone), 32'd1);
      checkOutput("t0DoneCycle", 32'(rDoneCycle), 32'd0);
      checkOutput("t0Busy", 32'(rBusy), 32'd1);

      // 7: one low coin, residue 2 cannot be paid.
      expCoins.push_back(2'd1);
      runPayout(8'd7, 0, 1'b0);
      checkOutput("t7Ejects", 32'(rEject), 32'd1);
      checkOutput("t7Err", 32'(rError), 32'd1);
      checkOutput("t7Done", 32'(rDone), 32'd0);
      checkOutput("t7Rem", 32'(rem), 32'd2);

      // 20 with no ack: times out after exactly 15 eject cycles.
      expCoins.push_back(2'd3);
      runPayout(8'd20, -1, 1'b0);
      checkOutput("toCycles", 32'(rEjectCycles), 32'd15);
      checkOutput("toErr", 32'(rError), 32'd1);
      checkOutput("toDone", 32'(rDone), 32'd0);
      checkOutput("toRem", 32'(rem), 32'd20);

      // Ack on the very edge the timer expires still succeeds.
      expCoins.push_back(2'd1);
      runPayout(8'd5, 14, 1'b0);
      checkOutput("edgeCycles", 32'(rEjectCycles), 32'd15);
      checkOutput("edgeDone", 32'(rDone), 32'd1);
      checkOutput("edgeErr", 32'(rError), 32'd0);
      checkOutput("edgeRem", 32'(rem), 32'd0);

      // Slow ejector: 15 = 10 + 5, three cycles per coin.
      expCoins.push_back(2'd2); expCoins.push_back(2'd1);
      runPayout(8'd15, 2, 1'b0);
      checkOutput("slowCycles", 32'(rEjectCycles), 32'd6);
      checkOutput("slowDone", 32'(rDone), 32'd1);

      // One coin of each kind: 45 runs dry with 10 unpaid.
      useB = 1'b1;
      @(negedge clk);
      expCoins.push_back(2'd3); expCoins.push_back(2'd2); expCoins.push_back(2'd1);
      runPayout(8'd45, 0, 1'b0);
      checkOutput("dryEjects", 32'(rEject), 32'd3);
      checkOutput("dryErr", 32'(rError), 32'd1);
      checkOutput("dryRem", 32'(rem), 32'd10);
      checkOutput("dryEmpty", 32'(invEmpty), 32'd7);

      // Start together with refill: start wins, stock stays empty.
      runPayout(8'd5, 0, 1'b1);
      checkOutput("bothEjects", 32'(rEject), 32'd0);
      checkOutput("bothErr", 32'(rError), 32'd1);
      checkOutput("bothRem", 32'(rem), 32'd5);
      checkOutput("bothEmpty", 32'(invEmpty), 32'd7);

      // Refill alone in IDLE restores stock.
      @(negedge clk); refill = 1'b1;
      @(negedge clk); refill = 1'b0;
      checkOutput("refillEmpty", 32'(invEmpty), 32'd0);

      // 35 drains the refilled single coins.
      expCoins.push_back(2'd3); expCoins.push_back(2'd2); expCoins.push_back(2'd1);
      runPayout(8'd35, 0, 1'b0);
      checkOutput("b35Done", 32'(rDone), 32'd1);
      checkOutput("b35Empty", 32'(invEmpty), 32'd7);

      // 40 on A: re-pulse start while busy, then reset during EJECT.
      useB = 1'b0;
      applyStimulus(8'd40, 1'b0);
      @(negedge clk);
      checkOutput("r40Eject", 32'(coinEject), 32'd1);
      checkOutput("r40Sel", 32'(coinSel), 32'd3);
      amount = 8'd5;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      checkOutput("r40Busy", 32'(busy), 32'd1);
      checkOutput("r40RemHeld", 32'(rem), 32'd40);
      checkOutput("r40SelHeld", 32'(coinSel), 32'd3);
      rst_n = 1'b0;
      #1;
      checkOutput("r40RstEject", 32'(coinEject), 32'd0);
      checkOutput("r40RstBusy", 32'(busy), 32'd0);
      checkOutput("r40RstDone", 32'(done), 32'd0);
      checkOutput("r40RstErr", 32'(err), 32'd0);
      checkOutput("r40RstEmptyB", 32'(emB), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // After reset a fresh 40 pays out as two high coins.
      expCoins.push_back(2'd3); expCoins.push_back(2'd3);
      runPayout(8'd40, 0, 1'b0);
      checkOutput("p40Ejects", 32'(rEject), 32'd2);
      checkOutput("p40Done", 32'(rDone), 32'd1);
      checkOutput("p40Rem", 32'(rem), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
